// File: rtl/pipe_wallace_mul.sv
// Pipelined Wallace-tree multiplier: W x W -> 2W, signed (Baugh-Wooley) or unsigned per operation.
// Latency STAGES cycles, one result per cycle, valid/ready backpressure with bubble collapse.
module pipe_wallace_mul #(
   parameter int W      = 16,
   parameter int STAGES = 3,
   parameter int TAG_W  = 4
) (
   input  logic               clk,
   input  logic               arst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [W-1:0]       in_a,
   input  logic [W-1:0]       in_b,
   input  logic               in_signed,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*W-1:0]     out_result,
   output logic [TAG_W-1:0]   out_tag,
   output logic               busy
);

   localparam int PW = 2 * W;
   // W partial-product rows plus one row holding the Baugh-Wooley correction constants.
   localparam int NR = W + 1;

   typedef logic [NR-1:0][PW-1:0] rows_t;

   function automatic int num_levels(input int n0);
      int n;
      int l;
      n = n0;
      l = 0;
      for (int i = 0; i < 64; i++) begin
         if (n > 2) begin
            n = n - n / 3;
            l = l + 1;
         end
      end
      return l;
   endfunction

   localparam int L = num_levels(NR);

   function automatic int seg_hi(input int s);
      if (s >= STAGES - 1) return L;
      return (L * (s + 1)) / STAGES;
   endfunction

   function automatic int seg_lo(input int s);
      if (s == 0) return 0;
      return seg_hi(s - 1);
   endfunction

   // One Wallace level on the first n rows; rows at or above n are zero and stay zero.
   function automatic rows_t csa_level(input rows_t x, input int n);
      rows_t y;
      int    nfa;
      int    base;
      y   = '0;
      nfa = n / 3;
      for (int g = 0; g < NR / 3; g++) begin
         if (g < nfa) begin
            y[2*g]   = x[3*g] ^ x[3*g+1] ^ x[3*g+2];
            y[2*g+1] = ((x[3*g] & x[3*g+1]) | (x[3*g] & x[3*g+2]) |
                        (x[3*g+1] & x[3*g+2])) << 1;
         end
      end
      base = 3 * nfa;
      if (n - base == 2) begin
         y[2*nfa]   = x[base] ^ x[base+1];
         y[2*nfa+1] = (x[base] & x[base+1]) << 1;
      end else if (n - base == 1) begin
         y[2*nfa] = x[base];
      end
      return y;
   endfunction

   // Levels lo..hi-1 of the tree; the final segment also resolves the last two rows into row 0.
   function automatic rows_t stage_fn(input rows_t x, input int lo, input int hi, input logic last);
      rows_t          y;
      int             n;
      logic [PW-1:0]  sum;
      y = x;
      n = NR;
      for (int j = 0; j < L; j++) begin
         if (j >= lo && j < hi) y = csa_level(y, n);
         n = n - n / 3;
      end
      if (last) begin
         sum  = y[0] + y[1];
         y    = '0;
         y[0] = sum;
      end
      return y;
   endfunction

   logic [W-1:0]        w_row;
   rows_t               w_pp;
   rows_t               w_src  [STAGES];
   rows_t               w_nxt  [STAGES];
   logic [TAG_W-1:0]    w_tsrc [STAGES];
   logic [STAGES-1:0]   w_free;
   logic [STAGES-1:0]   w_adv;
   logic [STAGES-1:0]   w_load;
   logic                w_dn;
   logic                w_up;

   rows_t               r_rows [STAGES];
   logic [TAG_W-1:0]    r_tag  [STAGES];
   logic [STAGES-1:0]   r_v;

   always_comb begin
      w_pp  = '0;
      w_row = '0;
      for (int i = 0; i < W; i++) begin
         w_row = in_a & {W{in_b[i]}};
         if (in_signed) begin
            if (i < W - 1) w_row[W-1]   = ~w_row[W-1];
            else           w_row[W-2:0] = ~w_row[W-2:0];
         end
         w_pp[i] = {{W{1'b0}}, w_row} << i;
      end
      if (in_signed) begin
         w_pp[W][W]    = 1'b1;
         w_pp[W][PW-1] = 1'b1;
      end
   end

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      if (s == 0) begin : g_first
         assign w_src[s]  = w_pp;
         assign w_tsrc[s] = in_tag;
      end else begin : g_next
         assign w_src[s]  = r_rows[s-1];
         assign w_tsrc[s] = r_tag[s-1];
      end
      assign w_nxt[s] = stage_fn(w_src[s], seg_lo(s), seg_hi(s), s == STAGES - 1);
   end

   // Free/advance ripple from the output back to the input; load ripples forward.
   always_comb begin
      w_adv  = '0;
      w_free = '0;
      w_load = '0;
      w_dn   = out_ready;
      w_up   = in_valid;
      for (int k = STAGES - 1; k >= 0; k--) begin
         w_adv[k]  = r_v[k] & w_dn;
         w_free[k] = ~r_v[k] | w_adv[k];
         w_dn      = w_free[k];
      end
      for (int k = 0; k < STAGES; k++) begin
         w_load[k] = w_free[k] & w_up;
         w_up      = r_v[k];
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_v <= '0;
         for (int k = 0; k < STAGES; k++) begin
            r_rows[k] <= '0;
            r_tag[k]  <= '0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (w_load[k]) begin
               r_v[k]    <= 1'b1;
               r_rows[k] <= w_nxt[k];
               r_tag[k]  <= w_tsrc[k];
            end else if (w_adv[k]) begin
               r_v[k] <= 1'b0;
            end
         end
      end
   end

   assign in_ready   = w_free[0];
   assign out_valid  = r_v[STAGES-1];
   assign out_result = r_rows[STAGES-1][0];
   assign out_tag    = r_tag[STAGES-1];
   assign busy       = |r_v;

endmodule
